mem_ctrl: RTL and testbench

- Memory-side responder for the core's fetch and load/store request interfaces. It serves the instruction cache's word-fetch requests and the load/store buffer's 1/2/4-byte accesses.
- Each access is serialised onto the byte-wide synchronous RAM/IO bus, one byte per cycle, little-endian.
- Sits between the instruction cache and LSB on one side and the top-level RAM/IO port on the other.
- Holds one outstanding transaction at a time, with fixed priority to load/store.

---
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves word fetches and 1/2/4-byte load/stores over an 8-bit RAM/IO bus.
// Build option: define IO_STALL_EN to stall IO-region writes while the UART TX buffer reports full.
module mem_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_req,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic              is_ls_q, is_ls_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    // The RAM keeps answering while rdy is low, so the byte that was in flight
    // when the freeze began is parked here and consumed on the first live cycle.
    logic              stall_q;
    logic [7:0]        shadow_q;

    logic [31:0]       buf_nx;
    logic [7:0]        byte_in;
    logic              io_stall;

`ifdef IO_STALL_EN
    logic              io_full_q;
`else
    logic              unused_io;
    assign unused_io = io_buffer_full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 2'd0;
            is_ls_q    <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            stall_q    <= 1'b0;
            shadow_q   <= 8'd0;
`ifdef IO_STALL_EN
            io_full_q  <= 1'b0;
`endif
        end else begin
            stall_q <= !rdy;
            if (!rdy && !stall_q) begin
                shadow_q <= mem_din;
            end
            if (rdy) begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                last_q     <= last_d;
                is_ls_q    <= is_ls_d;
                mem_a_q    <= mem_a_d;
                mem_dout_q <= mem_dout_d;
                wdata_q    <= wdata_d;
                buf_q      <= buf_d;
                if_data_q  <= if_data_d;
                ls_rdata_q <= ls_rdata_d;
`ifdef IO_STALL_EN
                io_full_q  <= io_buffer_full;
`endif
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        is_ls_d    = is_ls_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        buf_nx     = buf_q;
        byte_in    = stall_q ? shadow_q : mem_din;
        mem_wr     = 1'b0;
        if_done    = 1'b0;
        ls_done    = 1'b0;
        io_stall   = 1'b0;
`ifdef IO_STALL_EN
        io_stall   = io_full_q && (mem_a_q[17:16] == IO_BASE_HI);
`endif

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (ls_req) begin
                    is_ls_d    = 1'b1;
                    last_d     = (ls_size == 2'd0) ? 2'd0 : (ls_size == 2'd1) ? 2'd1 : 2'd3;
                    mem_a_d    = ls_addr;
                    wdata_d    = ls_wdata;
                    mem_dout_d = ls_wdata[7:0];
                    buf_d      = 32'd0;
                    state_d    = ls_wr ? WRITE : READ;
                end else if (if_req) begin
                    is_ls_d = 1'b0;
                    last_d  = 2'd3;
                    mem_a_d = if_addr;
                    buf_d   = 32'd0;
                    state_d = READ;
                end
            end

            READ: begin
                // Byte k returns one cycle after its address, i.e. while cnt_q == k+1.
                if (cnt_q != 3'd0) begin
                    buf_nx[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = byte_in;
                end
                buf_d = buf_nx;
                if (cnt_q == {1'b0, last_q} + 3'd1) begin
                    state_d = DONE;
                    if (is_ls_q) begin
                        ls_rdata_d = buf_nx;
                    end else begin
                        if_data_d = buf_nx;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < {1'b0, last_q}) begin
                        mem_a_d = mem_a_q + ADDR_W'(1);
                    end
                end
            end

            WRITE: begin
                mem_wr = rdy && !io_stall;
                if (!io_stall) begin
                    if (cnt_q == {1'b0, last_q}) begin
                        state_d = DONE;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = mem_a_q + ADDR_W'(1);
                        mem_dout_d = wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
                    end
                end
            end

            DONE: begin
                if_done = rdy && !is_ls_q;
                ls_done = rdy && is_ls_q;
                cnt_d   = 3'd0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model with registered read, done-pulse scoreboard and bus trace checks.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
    logic        if_req, if_done, ls_req, ls_wr, ls_done, mem_wr, io_buffer_full;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din, mem_dout;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_addr(if_addr), .if_req(if_req), .if_data(if_data), .if_done(if_done),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  ram [0:262143];
    logic [31:0] tr_a  [0:4095];
    logic        tr_wr [0:4095];
    logic [7:0]  tr_do [0:4095];

    function automatic logic [7:0] pat(input int i);
        return 8'(i ^ (i >> 8) ^ 32'h5C);
    endfunction

    function automatic logic [31:0] word_at(input int a);
        return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit l, input bit c, input logic [31:0] d, input int t);
        exp_t e;
        e.is_ls = l;
        e.chk   = c;
        e.data  = d;
        e.cyc   = t;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_ls, input int budget);
        int n = 0;
        while (!(is_ls ? ls_done : if_done) && n < budget) begin
            step();
            n++;
        end
        check(is_ls ? "ls_done_timeout" : "if_done_timeout", 32'(n < budget), 32'd1);
    endtask

    // Byte-wide synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 4096) begin
            tr_a[cyc]  = mem_a;
            tr_wr[cyc] = mem_wr;
            tr_do[cyc] = mem_dout;
        end
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("no_done_expected", {30'd0, if_done, ls_done}, 32'd0);
            end else if (if_done || ls_done) begin
                check("done_exclusive", {31'd0, if_done & ls_done}, 32'd0);
                e_mon = exp_q.pop_front();
                check("done_kind", {31'd0, ls_done}, {31'd0, e_mon.is_ls});
                check("done_cycle", cyc, e_mon.cyc);
                if (e_mon.chk) check("done_data", e_mon.is_ls ? ls_rdata : if_data, e_mon.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int   A;
        logic acc;
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 262144; i++) ram[i] = pat(i);
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ram[32'h2000] = 8'hFE; ram[32'h2001] = 8'hFF;
        ram[32'h3000] = 8'h11; ram[32'h3001] = 8'h22; ram[32'h3002] = 8'h33; ram[32'h3003] = 8'h44;

        repeat (3) step();
        rst = 1'b0;
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_ls_done", {31'd0, ls_done}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        mon_en = 1'b1;

        // Word fetch at 0x100, request held through the done cycle.
        step(); A = cyc;
        if_addr = 32'h100; if_req = 1'b1;
        push(1'b0, 1'b1, 32'h00100513, A + 6);
        wait_done(1'b0, 20);
        step(); if_req = 1'b0;
        step();
        for (int k = 0; k < 4; k++) check("fetch_mem_a", tr_a[A + 1 + k], 32'h100 + k);
        acc = 1'b0;
        for (int k = 1; k <= 6; k++) acc = acc | tr_wr[A + k];
        check("fetch_no_write", {31'd0, acc}, 32'd0);
        check("fetch_no_accept_in_done", tr_a[A + 7], 32'h103);

        // Byte store to the IO region.
        step(); A = cyc;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
        push(1'b1, 1'b0, 32'd0, A + 2);
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0;
        step();
        check("sb_wr", {31'd0, tr_wr[A + 1]}, 32'd1);
        check("sb_mem_a", tr_a[A + 1], 32'h30000);
        check("sb_dout", {24'd0, tr_do[A + 1]}, 32'h41);
        check("sb_wr_off_in_done", {31'd0, tr_wr[A + 2]}, 32'd0);
        check("sb_ram", {24'd0, ram[32'h30000]}, 32'h41);

        // Simultaneous requests: the load wins, the fetch follows.
        step(); A = cyc;
        if_addr = 32'h104; if_req = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd3; ls_addr = 32'h3000;
        push(1'b1, 1'b1, 32'h44332211, A + 6);
        push(1'b0, 1'b1, word_at(32'h104), A + 13);
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0;
        wait_done(1'b0, 20);
        step(); if_req = 1'b0;
        step();
        check("cont_fetch_addr", tr_a[A + 8], 32'h104);
        check("cont_ls_rdata_held", ls_rdata, 32'h44332211);

        // Halfword load: upper bytes must be cleared.
        step(); A = cyc;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h2000;
        push(1'b1, 1'b1, 32'h0000FFFE, A + 4);
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0;
        step();

        // Address wrap at the top of the address space.
        step(); A = cyc;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'hFFFFFFFF;
        push(1'b1, 1'b1, {16'd0, pat(0), pat(32'h3FFFF)}, A + 4);
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0;
        step();
        check("wrap_a0", tr_a[A + 1], 32'hFFFFFFFF);
        check("wrap_a1", tr_a[A + 2], 32'h0);

        // Reset during byte 1 of a word store: aborted, no done pulse.
        step(); A = cyc;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h500; ls_wdata = 32'hDEADBEEF;
        step();
        step(); rst = 1'b1;
        step(); rst = 1'b0; ls_req = 1'b0;
        step();
        step();
        check("rst_mid_byte1_wr", {31'd0, tr_wr[A + 2]}, 32'd1);
        check("rst_mid_wr_off", {31'd0, tr_wr[A + 3]}, 32'd0);
        check("rst_mid_mem_a", tr_a[A + 3], 32'd0);
        check("rst_mid_ram501", {24'd0, ram[32'h501]}, 32'hBE);
        check("rst_mid_ram502", {24'd0, ram[32'h502]}, {24'd0, pat(32'h502)});

        // rdy low for three cycles in the middle of a fetch.
        step(); A = cyc;
        if_addr = 32'h200; if_req = 1'b1;
        push(1'b0, 1'b1, word_at(32'h200), A + 9);
        step();
        step(); rdy = 1'b0;
        step();
        step();
        step(); rdy = 1'b1;
        wait_done(1'b0, 20);
        step(); if_req = 1'b0;
        step();
        check("rdy_rd_hold_a", tr_a[A + 4], 32'h201);
        check("rdy_rd_resume_a", tr_a[A + 6], 32'h202);

        // rdy low for two cycles at the start of a halfword store.
        step(); A = cyc;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h600; ls_wdata = 32'h0000BBAA;
        push(1'b1, 1'b0, 32'd0, A + 5);
        step(); rdy = 1'b0;
        step();
        step(); rdy = 1'b1;
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0;
        step();
        check("rdy_wr_gated0", {31'd0, tr_wr[A + 1]}, 32'd0);
        check("rdy_wr_gated1", {31'd0, tr_wr[A + 2]}, 32'd0);
        check("rdy_wr_resume", {31'd0, tr_wr[A + 3]}, 32'd1);
        check("rdy_wr_a0", tr_a[A + 3], 32'h600);
        check("rdy_wr_dout0", {24'd0, tr_do[A + 3]}, 32'hAA);
        check("rdy_wr_a1", tr_a[A + 4], 32'h601);
        check("rdy_wr_ram", {16'd0, ram[32'h601], ram[32'h600]}, 32'h0000BBAA);

        // IO store while the UART buffer reports full for five cycles.
        step(); A = cyc;
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h5A;
`ifdef IO_STALL_EN
        push(1'b1, 1'b0, 32'd0, A + 7);
        repeat (5) step();
        io_buffer_full = 1'b0;
`else
        push(1'b1, 1'b0, 32'd0, A + 2);
`endif
        wait_done(1'b1, 20);
        step(); ls_req = 1'b0; io_buffer_full = 1'b0;
        step();
`ifdef IO_STALL_EN
        check("io_stalled", {31'd0, tr_wr[A + 5]}, 32'd0);
        check("io_first_write", {31'd0, tr_wr[A + 6]}, 32'd1);
`else
        check("io_no_stall_write", {31'd0, tr_wr[A + 1]}, 32'd1);
`endif
        check("io_ram", {24'd0, ram[32'h30000]}, 32'h5A);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
